// File: rtl/note_seq_pkg.sv
// Shared encodings for the note sequencer: sequencing modes and ping-pong direction.
package note_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tempo_prescaler.sv
// Tempo prescaler: emits a tick every tempo_div+1 enabled cycles.
// The >= compare means lowering tempo_div mid-count ticks on the next cycle.
module tempo_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] tempo_div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count_q;
    logic [PRESCALE_W-1:0] count_d;

    // Tick at terminal count; count holds while disabled, clears on restart.
    always_comb begin
        tick    = enable && (count_q >= tempo_div);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tick ? '0 : count_q + PRESCALE_W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: steps a note index up/down/ping-pong/hold on each advance
// event and decodes it to a one-hot buzzer drive.
//
//   dir      | meaning
//   DIR_UP   | ping-pong currently climbing toward NOTE_COUNT-1
//   DIR_DOWN | ping-pong currently descending toward 0
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter  int NOTE_COUNT = 8,
    parameter  int PRESCALE_W = 16,
    localparam int IDX_W      = $clog2(NOTE_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] tempo_div,
    input  logic                  step,
    input  logic                  restart,
    input  logic                  mute,
    output logic [IDX_W-1:0]      note_index,
    output logic [NOTE_COUNT-1:0] note_onehot,
    output logic                  beat,
    output logic                  wrap
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTE_COUNT - 1);

    logic             tick;
    logic             advance;
    mode_e            mode_sel;
    logic [IDX_W-1:0] note_index_q, note_index_d;
    logic             dir_q, dir_d;
    logic             beat_q, beat_d;
    logic             wrap_q, wrap_d;

    tempo_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (restart),
        .tempo_div (tempo_div),
        .tick      (tick)
    );

    assign mode_sel = mode_e'(mode);
    // step only counts as a manual advance while free-running is off.
    assign advance  = tick || (step && !enable);

    // Next index/direction/status; restart overrides any advance.
    always_comb begin
        note_index_d = note_index_q;
        dir_d        = dir_q;
        beat_d       = 1'b0;
        wrap_d       = 1'b0;
        if (restart) begin
            note_index_d = '0;
            dir_d        = DIR_UP;
        end else if (advance) begin
            beat_d = 1'b1;
            case (mode_sel)
                MODE_UP: begin
                    if (note_index_q == LAST_IDX) begin
                        note_index_d = '0;
                        wrap_d       = 1'b1;
                    end else begin
                        note_index_d = note_index_q + IDX_W'(1);
                    end
                end
                MODE_DOWN: begin
                    if (note_index_q == '0) begin
                        note_index_d = LAST_IDX;
                        wrap_d       = 1'b1;
                    end else begin
                        note_index_d = note_index_q - IDX_W'(1);
                    end
                end
                MODE_PINGPONG: begin
                    if (dir_q == DIR_UP) begin
                        if (note_index_q == LAST_IDX) begin
                            dir_d        = DIR_DOWN;
                            note_index_d = LAST_IDX - IDX_W'(1);
                        end else begin
                            note_index_d = note_index_q + IDX_W'(1);
                        end
                    end else begin
                        if (note_index_q == '0) begin
                            dir_d        = DIR_UP;
                            note_index_d = IDX_W'(1);
                            wrap_d       = 1'b1;
                        end else begin
                            note_index_d = note_index_q - IDX_W'(1);
                        end
                    end
                end
                default: begin
                    note_index_d = note_index_q;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_index_q <= '0;
            dir_q        <= DIR_UP;
            beat_q       <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            note_index_q <= note_index_d;
            dir_q        <= dir_d;
            beat_q       <= beat_d;
            wrap_q       <= wrap_d;
        end
    end

    assign note_index  = note_index_q;
    assign beat        = beat_q;
    assign wrap        = wrap_q;
    assign note_onehot = mute ? '0 : (NOTE_COUNT'(1) << note_index_q);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: an 8-note and a 5-note instance share stimulus and
// are compared every cycle against an arithmetic model of the sequencing rules.
module tb_note_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] tempo_div;
    logic        step;
    logic        restart;
    logic        mute;

    logic [2:0]  idx8, idx5;
    logic [7:0]  oh8;
    logic [4:0]  oh5;
    logic        beat8, beat5, wrap8, wrap5;

    int n_tests = 0;
    int n_fail  = 0;

    int nc[2] = '{8, 5};
    int m_idx[2];
    int m_dir[2];
    int m_beat[2];
    int m_wrap[2];
    int m_pre;

    note_sequencer #(.NOTE_COUNT(8), .PRESCALE_W(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .tempo_div(tempo_div), .step(step), .restart(restart), .mute(mute),
        .note_index(idx8), .note_onehot(oh8), .beat(beat8), .wrap(wrap8)
    );

    note_sequencer #(.NOTE_COUNT(5), .PRESCALE_W(16)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .tempo_div(tempo_div), .step(step), .restart(restart), .mute(mute),
        .note_index(idx5), .note_onehot(oh5), .beat(beat5), .wrap(wrap5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0; m_dir[k] = 0; m_beat[k] = 0; m_wrap[k] = 0;
        end
    endtask

    // One rising edge of the reference: positions move on a ring (up/down)
    // or bounce between the ends (ping-pong); dir 0 = climbing, 1 = descending.
    task automatic model_edge();
        bit adv;
        int n;
        adv = (enable && m_pre >= int'(tempo_div)) || (step && !enable);
        if (restart) begin
            model_reset();
            return;
        end
        if (enable) m_pre = (m_pre >= int'(tempo_div)) ? 0 : m_pre + 1;
        for (int k = 0; k < 2; k++) begin
            n = nc[k];
            m_beat[k] = adv ? 1 : 0;
            m_wrap[k] = 0;
            if (adv) begin
                case (mode)
                    2'b00: begin
                        m_idx[k] = (m_idx[k] + 1) % n;
                        m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
                    end
                    2'b01: begin
                        m_idx[k] = (m_idx[k] + n - 1) % n;
                        m_wrap[k] = (m_idx[k] == n - 1) ? 1 : 0;
                    end
                    2'b10: begin
                        if (m_dir[k] == 0 && m_idx[k] == n - 1) begin
                            m_dir[k] = 1;
                        end else if (m_dir[k] == 1 && m_idx[k] == 0) begin
                            m_dir[k] = 0;
                            m_wrap[k] = 1;
                        end
                        m_idx[k] = m_idx[k] + ((m_dir[k] == 1) ? -1 : 1);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_all();
        chk("idx8",  32'(idx8),  32'(m_idx[0]));
        chk("oh8",   32'(oh8),   mute ? 32'd0 : (32'd1 << m_idx[0]));
        chk("beat8", 32'(beat8), 32'(m_beat[0]));
        chk("wrap8", 32'(wrap8), 32'(m_wrap[0]));
        chk("idx5",  32'(idx5),  32'(m_idx[1]));
        chk("oh5",   32'(oh5),   mute ? 32'd0 : (32'd1 << m_idx[1]));
        chk("beat5", 32'(beat5), 32'(m_beat[1]));
        chk("wrap5", 32'(wrap5), 32'(m_wrap[1]));
    endtask

    // Inputs change at the falling edge; the model follows the rising edge;
    // outputs are compared at the next falling edge.
    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    int wrap_seen;

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 2'b00; tempo_div = '0;
        step = 1'b0; restart = 1'b0; mute = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Up mode, beat every 4 cycles, full cycle 0..7 and wrap back.
        mode = 2'b00; tempo_div = 16'd3; enable = 1'b1;
        run(36);

        // Ping-pong at one beat per cycle.
        restart = 1'b1; run(1); restart = 1'b0;
        mode = 2'b10; tempo_div = 16'd0;
        run(14);

        // Down from 0 with tempo 1, then muted while still advancing.
        restart = 1'b1; run(1); restart = 1'b0;
        mode = 2'b01; tempo_div = 16'd1;
        run(6);
        mute = 1'b1; run(6); mute = 1'b0;

        // Manual stepping with enable low; step held with enable high does nothing extra.
        restart = 1'b1; run(1); restart = 1'b0;
        enable = 1'b0; mode = 2'b00;
        step = 1'b1; run(2); step = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1; run(1); step = 1'b0; run(2);
        end
        tempo_div = 16'd5; enable = 1'b1; step = 1'b1; run(9); step = 1'b0;

        // Restart mid-run, then asynchronous reset between clock edges.
        tempo_div = 16'd7; run(11);
        restart = 1'b1; run(1); restart = 1'b0;
        run(12);
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        rst_n = 1'b1;
        run(10);

        // Hold then switch to up; wrap must stay low while holding.
        mode = 2'b11; tempo_div = 16'd2;
        wrap_seen = 0;
        for (int c = 0; c < 9; c++) begin
            run(1);
            if (wrap8 || wrap5) wrap_seen++;
        end
        chk("hold_nowrap", 32'(wrap_seen), 32'd0);
        mode = 2'b00; run(6);

        // Mid-count reduction of tempo_div.
        tempo_div = 16'd9; run(6); tempo_div = 16'd1; run(6);

        // Randomized traffic.
        for (int r = 0; r < 500; r++) begin
            enable  = ($urandom_range(0, 3) != 0);
            step    = $urandom_range(0, 1);
            restart = ($urandom_range(0, 39) == 0);
            mute    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) tempo_div = 16'($urandom_range(0, 4));
            run(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
